// File: rtl/mgmt_rx_frame_buffer_if.sv
// Signal bundle between the management RX MAC path, the frame buffer and its reader.
// master = MAC stream source plus frame reader; slave = the frame buffer.
interface mgmt_rx_frame_buffer_if;
    logic        rx_start;
    logic        rx_data_valid;
    logic [2:0]  rx_bytes_valid;
    logic [31:0] rx_data;
    logic        rx_commit;
    logic        rx_drop;
    logic        link_up;

    logic        rd_frame_ready;
    logic [10:0] rd_frame_len;
    logic        rd_en;
    logic        rd_discard;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic [2:0]  rd_bytes_valid;
    logic        rd_last;

    logic [31:0] frames_committed;
    logic [31:0] frames_dropped;
    logic        dbg_wr_active;

    // Handshake: rx_* words are taken on every clock edge where they are presented
    // (no backpressure). rd_en/rd_discard act only while rd_frame_ready is high;
    // a popped word appears with rd_data_valid exactly one cycle after rd_en.
    modport master (
        output rx_start, rx_data_valid, rx_bytes_valid, rx_data, rx_commit, rx_drop, link_up,
        output rd_en, rd_discard,
        input  rd_frame_ready, rd_frame_len, rd_data_valid, rd_data, rd_bytes_valid, rd_last,
        input  frames_committed, frames_dropped, dbg_wr_active
    );

    modport slave (
        input  rx_start, rx_data_valid, rx_bytes_valid, rx_data, rx_commit, rx_drop, link_up,
        input  rd_en, rd_discard,
        output rd_frame_ready, rd_frame_len, rd_data_valid, rd_data, rd_bytes_valid, rd_last,
        output frames_committed, frames_dropped, dbg_wr_active
    );
endinterface

// File: rtl/mgmt_rx_frame_buffer.sv
// Receive frame buffer: stores committed RX frames in a word RAM with a per-frame length
// queue; uncommitted, oversize or overflowing frames are rolled back and never delivered.
module mgmt_rx_frame_buffer #(
    parameter int DEPTH           = 1024,
    parameter int MAX_FRAMES      = 16,
    parameter int MAX_FRAME_BYTES = 1536
) (
    input logic                   clk,
    input logic                   rst,
    mgmt_rx_frame_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int QW = $clog2(MAX_FRAMES);
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [QW:0]   LQ_ONE   = 1;
    localparam logic [QW:0]   LQ_FULL  = (QW+1)'(MAX_FRAMES);
    localparam logic [11:0]   MAX_B    = 12'(MAX_FRAME_BYTES);

    typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;
    wr_state_t wr_state;

    logic [34:0]   mem [DEPTH];
    logic [10:0]   lq_mem [MAX_FRAMES];
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [QW:0]   lq_wr, lq_rd;
    logic [10:0]   byte_cnt;
    logic          bad;
    logic [31:0]   committed, dropped;

    logic [PW-1:0] used, wr_ptr_nx;
    logic [11:0]   sum;
    logic [10:0]   cnt_nx;
    logic          data_ok, active_cycle, mem_we, bad_nx, lq_push, lq_full;

    logic [10:0]   head_len;
    logic [9:0]    head_words, head_used, remaining;
    logic          frame_ready, do_pop, do_discard;
    logic          rd_valid_q, rd_last_q;
    logic [31:0]   rd_data_q;
    logic [2:0]    rd_bv_q;

    assign lq_full = (lq_wr - lq_rd) == LQ_FULL;

    // Word accepted this cycle only inside an ACTIVE frame not being aborted or restarted.
    always_comb begin
        used         = wr_ptr - rd_ptr;
        sum          = {1'b0, byte_cnt} + 12'(bus.rx_bytes_valid);
        data_ok      = (used != DEPTH_P) && (sum <= MAX_B);
        active_cycle = bus.link_up && !bus.rx_start && !bus.rx_drop && (wr_state == WR_ACTIVE);
        mem_we       = active_cycle && bus.rx_data_valid && data_ok;
        wr_ptr_nx    = mem_we ? wr_ptr + PTR_ONE : wr_ptr;
        cnt_nx       = mem_we ? sum[10:0] : byte_cnt;
        bad_nx       = bad || (bus.rx_data_valid && !data_ok);
        lq_push      = active_cycle && bus.rx_commit && !bad_nx && (cnt_nx != 11'd0) && !lq_full;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= {bus.rx_bytes_valid, bus.rx_data};
        if (lq_push) lq_mem[lq_wr[QW-1:0]] <= cnt_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state   <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            lq_wr      <= '0;
            byte_cnt   <= '0;
            bad        <= 1'b0;
            committed  <= '0;
            dropped    <= '0;
        end else if (!bus.link_up) begin
            wr_ptr   <= commit_ptr;
            wr_state <= WR_IDLE;
        end else if (bus.rx_start) begin
            wr_ptr   <= commit_ptr;
            byte_cnt <= '0;
            bad      <= 1'b0;
            wr_state <= WR_ACTIVE;
        end else if (wr_state == WR_ACTIVE) begin
            if (bus.rx_drop) begin
                wr_ptr   <= commit_ptr;
                wr_state <= WR_IDLE;
            end else if (bus.rx_commit) begin
                if (lq_push) begin
                    commit_ptr <= wr_ptr_nx;
                    wr_ptr     <= wr_ptr_nx;
                    lq_wr      <= lq_wr + LQ_ONE;
                    committed  <= committed + 32'd1;
                end else begin
                    wr_ptr  <= commit_ptr;
                    dropped <= dropped + 32'd1;
                end
                wr_state <= WR_IDLE;
            end else begin
                wr_ptr   <= wr_ptr_nx;
                byte_cnt <= cnt_nx;
                bad      <= bad_nx;
            end
        end
    end

    // Remaining words of the head frame = ceil(len/4) minus words already popped.
    always_comb begin
        frame_ready = lq_wr != lq_rd;
        head_len    = lq_mem[lq_rd[QW-1:0]];
        head_words  = 10'(({1'b0, head_len} + 12'd3) >> 2);
        remaining   = head_words - head_used;
        do_discard  = bus.rd_discard && frame_ready;
        do_pop      = bus.rd_en && frame_ready && !bus.rd_discard;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            lq_rd      <= '0;
            head_used  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_bv_q    <= '0;
        end else begin
            rd_valid_q <= do_pop;
            rd_last_q  <= do_pop && (remaining == 10'd1);
            if (do_discard) begin
                rd_ptr    <= rd_ptr + PW'(remaining);
                lq_rd     <= lq_rd + LQ_ONE;
                head_used <= '0;
            end else if (do_pop) begin
                {rd_bv_q, rd_data_q} <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + PTR_ONE;
                if (remaining == 10'd1) begin
                    lq_rd     <= lq_rd + LQ_ONE;
                    head_used <= '0;
                end else begin
                    head_used <= head_used + 10'd1;
                end
            end
        end
    end

    assign bus.rd_frame_ready   = frame_ready;
    assign bus.rd_frame_len     = frame_ready ? head_len : 11'd0;
    assign bus.rd_data_valid    = rd_valid_q;
    assign bus.rd_data          = rd_data_q;
    assign bus.rd_bytes_valid   = rd_bv_q;
    assign bus.rd_last          = rd_last_q;
    assign bus.frames_committed = committed;
    assign bus.frames_dropped   = dropped;
    assign bus.dbg_wr_active    = (wr_state == WR_ACTIVE);
endmodule

// File: tb/tb_mgmt_rx_frame_buffer.sv
// Self-checking bench for mgmt_rx_frame_buffer: frame-level reference model, expected-word
// queue checked by an independent monitor, directed scenarios then randomized traffic.
module tb_mgmt_rx_frame_buffer;
    localparam int DEPTH      = 128;
    localparam int MAX_FRAMES = 16;
    localparam int MAX_FB     = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mgmt_rx_frame_buffer_if bus();

    mgmt_rx_frame_buffer #(
        .DEPTH(DEPTH), .MAX_FRAMES(MAX_FRAMES), .MAX_FRAME_BYTES(MAX_FB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed words in delivery order, their frame lengths, frame in progress.
    logic [34:0] m_words[$];
    int          m_lens[$];
    int          m_head_used = 0;
    logic [34:0] m_cur[$];
    int          m_cur_bytes = 0;
    bit          m_bad = 0;
    bit          m_active = 0;
    logic [31:0] m_committed = 0;
    logic [31:0] m_dropped = 0;
    logic [35:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int words_of(input int n);
        return (n + 3) / 4;
    endfunction

    task automatic m_reset();
        m_words.delete(); m_lens.delete(); m_cur.delete();
        m_head_used = 0; m_cur_bytes = 0; m_bad = 0; m_active = 0;
        m_committed = 0; m_dropped = 0;
        exp_q.delete();
    endtask

    task automatic m_start();
        m_active = 1; m_cur.delete(); m_cur_bytes = 0; m_bad = 0;
    endtask

    task automatic m_abort();
        m_active = 0; m_cur.delete();
    endtask

    task automatic m_data(input logic [2:0] bv, input logic [31:0] d);
        if (m_words.size() + m_cur.size() < DEPTH && m_cur_bytes + int'(bv) <= MAX_FB) begin
            m_cur.push_back({bv, d});
            m_cur_bytes += int'(bv);
        end else begin
            m_bad = 1;
        end
    endtask

    task automatic m_commit();
        if (!m_bad && m_cur_bytes > 0 && m_lens.size() < MAX_FRAMES) begin
            foreach (m_cur[i]) m_words.push_back(m_cur[i]);
            m_lens.push_back(m_cur_bytes);
            m_committed++;
        end else begin
            m_dropped++;
        end
        m_abort();
    endtask

    task automatic check_outputs();
        check("frame_ready", 64'(bus.rd_frame_ready), 64'(m_lens.size() > 0));
        check("frame_len", 64'(bus.rd_frame_len), 64'(m_lens.size() > 0 ? m_lens[0] : 0));
        check("frames_committed", 64'(bus.frames_committed), 64'(m_committed));
        check("frames_dropped", 64'(bus.frames_dropped), 64'(m_dropped));
        check("wr_active", 64'(bus.dbg_wr_active), 64'(m_active));
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr_cycle(input bit st, input bit dv, input logic [2:0] bv, input logic [31:0] d,
                            input bit cm, input bit dr, input bit lk);
        bus.rx_start = st; bus.rx_data_valid = dv; bus.rx_bytes_valid = bv; bus.rx_data = d;
        bus.rx_commit = cm; bus.rx_drop = dr; bus.link_up = lk;
        bus.rd_en = 1'b0; bus.rd_discard = 1'b0;
        if (!lk) m_abort();
        else if (st) m_start();
        else if (m_active) begin
            if (dr) m_abort();
            else begin
                if (dv) m_data(bv, d);
                if (cm) m_commit();
            end
        end
        tick();
    endtask

    task automatic rd_cycle(input bit en, input bit disc);
        int nw;
        logic [34:0] w;
        bit last;
        bus.rx_start = 0; bus.rx_data_valid = 0; bus.rx_commit = 0; bus.rx_drop = 0; bus.link_up = 1;
        bus.rd_en = en; bus.rd_discard = disc;
        if (m_lens.size() > 0) begin
            nw = words_of(m_lens[0]);
            if (disc) begin
                repeat (nw - m_head_used) void'(m_words.pop_front());
                void'(m_lens.pop_front());
                m_head_used = 0;
            end else if (en) begin
                w = m_words.pop_front();
                m_head_used++;
                last = (m_head_used == nw);
                exp_q.push_back({last, w});
                if (last) begin
                    void'(m_lens.pop_front());
                    m_head_used = 0;
                end
            end
        end
        tick();
    endtask

    // mode: 0 commit after data, 1 commit with last word, 2 rx_drop, 3 link loss mid-frame,
    // 4 restart (rx_start again) after two words, then commit
    task automatic send_frame(input int nbytes, input int mode);
        int nw;
        logic [2:0] bv;
        nw = words_of(nbytes);
        if (mode == 4) begin
            wr_cycle(1, 0, 0, 0, 0, 0, 1);
            wr_cycle(0, 1, 4, $urandom, 0, 0, 1);
            wr_cycle(0, 1, 4, $urandom, 0, 0, 1);
        end
        wr_cycle(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < nw; i++) begin
            bv = (i == nw - 1) ? 3'(nbytes - 4 * i) : 3'd4;
            if ($urandom_range(0, 3) == 0) wr_cycle(0, 0, 0, 0, 0, 0, 1);
            if (mode == 3 && i == nw / 2) begin
                wr_cycle(0, 0, 0, 0, 0, 0, 0);
                return;
            end
            wr_cycle(0, 1, bv, $urandom, (mode == 1 && i == nw - 1), 0, 1);
        end
        if (mode == 0 || mode == 4) wr_cycle(0, 0, 0, 0, 1, 0, 1);
        else if (mode == 2) wr_cycle(0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic drain();
        while (m_lens.size() > 0) rd_cycle(1, 0);
        rd_cycle(0, 0);
        rd_cycle(0, 0);
    endtask

    // Monitor: every word the DUT presents must match the oldest expected word.
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst && bus.rd_data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected no word at %0t", bus.rd_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("rd_word", 64'({bus.rd_last, bus.rd_bytes_valid, bus.rd_data}), 64'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected test end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, r, mode;
        bus.rx_start = 0; bus.rx_data_valid = 0; bus.rx_bytes_valid = 0; bus.rx_data = 0;
        bus.rx_commit = 0; bus.rx_drop = 0; bus.link_up = 1; bus.rd_en = 0; bus.rd_discard = 0;
        repeat (3) @(negedge clk);
        check_outputs();
        check("reset_rd_data_valid", 64'(bus.rd_data_valid), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        rst = 1'b0;
        tick();

        send_frame(60, 0);
        check("len_60", 64'(bus.rd_frame_len), 64'd60);
        drain();
        send_frame(61, 1);
        drain();
        rd_cycle(1, 0);                         // read with nothing queued is ignored
        wr_cycle(0, 1, 4, 32'hdead_beef, 1, 0, 1); // data/commit while idle are ignored

        send_frame(300, 0);                     // max length accepted
        send_frame(300, 0);                     // overflows the RAM
        drain();
        send_frame(8, 0);
        drain();
        send_frame(301, 0);                     // one byte over the limit
        send_frame(300, 0);
        send_frame(212, 0);                     // fills the RAM exactly
        send_frame(4, 0);                       // no space left
        drain();

        send_frame(64, 2);
        send_frame(64, 3);
        send_frame(64, 0);
        drain();

        send_frame(100, 0);
        send_frame(200, 0);
        send_frame(64, 0);
        rd_cycle(0, 1);
        rd_cycle(1, 0);
        rd_cycle(1, 0);
        rd_cycle(1, 1);                         // discard wins over rd_en
        check("head_after_discards", 64'(bus.rd_frame_len), 64'd64);
        drain();

        for (int i = 0; i < MAX_FRAMES + 1; i++) send_frame(8, 0);
        check("queue_full_drop", 64'(bus.frames_dropped), 64'(m_dropped));
        drain();
        send_frame(40, 4);
        drain();

        // Asynchronous reset mid-read and mid-write
        send_frame(100, 1);
        wr_cycle(1, 0, 0, 0, 0, 0, 1);
        wr_cycle(0, 1, 4, $urandom, 0, 0, 1);
        bus.rx_data_valid = 1; bus.rx_bytes_valid = 4; bus.rd_en = 1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_frame_ready", 64'(bus.rd_frame_ready), 64'd0);
        check("arst_frame_len", 64'(bus.rd_frame_len), 64'd0);
        check("arst_data_valid", 64'(bus.rd_data_valid), 64'd0);
        check("arst_data", 64'(bus.rd_data), 64'd0);
        check("arst_bytes_valid", 64'(bus.rd_bytes_valid), 64'd0);
        check("arst_last", 64'(bus.rd_last), 64'd0);
        check("arst_committed", 64'(bus.frames_committed), 64'd0);
        check("arst_dropped", 64'(bus.frames_dropped), 64'd0);
        check("arst_wr_active", 64'(bus.dbg_wr_active), 64'd0);
        bus.rx_data_valid = 0; bus.rd_en = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        send_frame(60, 0);
        drain();

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: nb = $urandom_range(1, 64);
                    6, 7, 8:          nb = $urandom_range(65, MAX_FB);
                    default:          nb = $urandom_range(MAX_FB - 10, MAX_FB + 10);
                endcase
                mode = $urandom_range(0, 4);
                send_frame(nb, mode);
            end else if (r < 8) begin
                repeat ($urandom_range(1, 20)) rd_cycle(1, 0);
            end else if (r == 8) begin
                rd_cycle(0, 1);
            end else begin
                rd_cycle(1'($urandom_range(0, 1)), 1);
            end
        end
        drain();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mgmt_rx_frame_buffer.md
# mgmt_rx_frame_buffer

Single-clock, parametrised receive frame buffer for the management Ethernet path. It accepts a 32-bit Ethernet RX stream with start/commit/drop framing and stores committed frames in block RAM. It keeps a per-frame byte-length queue, so software-facing logic (QSPI register bridge) can read a frame length up front, pop words, or discard a whole frame in one cycle. Oversize and overflowing frames are rolled back and counted, never partially delivered.

## Interface
- `DEPTH`, 1024: data RAM depth in 32-bit words; power of two, at least 2.
- `MAX_FRAMES`, 16: length-queue depth, i.e. the maximum number of committed frames held; power of two.
- `MAX_FRAME_BYTES`, 1536: a frame longer than this is dropped; must be at most 2047.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `rx_start` in 1: first cycle of a new frame.
- `rx_data_valid` in 1: `rx_data` holds frame bytes this cycle.
- `rx_bytes_valid` in 3: valid bytes in `rx_data`, range 1..4, MSB-first.
- `rx_data` in 32: frame data.
- `rx_commit` in 1: frame complete with good FCS.
- `rx_drop` in 1: frame bad; discard it.
- `link_up` in 1: low aborts any in-progress frame.
- `rd_frame_ready` out 1: at least one committed frame is queued.
- `rd_frame_len` out 11: byte length of the head frame; valid when `rd_frame_ready` is high.
- `rd_en` in 1: pop one word of the head frame.
- `rd_discard` in 1: discard the rest of the head frame.
- `rd_data_valid` out 1: `rd_data` is valid.
- `rd_data` out 32: popped word.
- `rd_bytes_valid` out 3: valid bytes in `rd_data`.
- `rd_last` out 1: `rd_data` is the final word of its frame.
- `frames_committed` out 32: wrapping count of accepted frames.
- `frames_dropped` out 32: wrapping count of frames lost to overflow, oversize or a full length queue; `rx_drop` and link loss do not increment it.

## Operation
- **Data storage**
  - The RAM stores `{bytes_valid, data}` (35 bits) per word.
  - Write side keeps `wr_ptr` and `commit_ptr`; read side keeps `rd_ptr`. All pointers are log2(DEPTH)+1 bits with a wrap bit.
  - Free space = DEPTH − (`wr_ptr` − `rd_ptr`).
- **Write states**
  - IDLE: on `rx_start`, set `wr_ptr`=`commit_ptr`, clear byte count and the `bad` flag, go to ACTIVE.
  - ACTIVE, on `rx_data_valid`: if free space > 0 and byte count + `rx_bytes_valid` ≤ `MAX_FRAME_BYTES`, write the word, advance `wr_ptr` and add to byte count; otherwise set `bad`.
  - ACTIVE, on `rx_commit` (a data word in the same cycle is included first):
    - Commit if `bad` is clear, byte count > 0 and the length queue is not full: `commit_ptr`←new `wr_ptr`, push the length, increment `frames_committed`.
    - Otherwise: `wr_ptr`←`commit_ptr`, increment `frames_dropped`.
    - Either way, go to IDLE.
  - ACTIVE, on `rx_drop`, or `link_up` low in any state: `wr_ptr`←`commit_ptr`, go to IDLE, no counter change.
  - `rx_start` while in ACTIVE: silently roll back the current frame and restart.
  - Data, commit or drop while in IDLE: ignored.
- **Read side**
  - The head entry of the length queue drives `rd_frame_len`. A words-remaining counter loads ceil(len/4) when a frame becomes head.
  - `rd_en` with `rd_frame_ready` high: read RAM[`rd_ptr`], advance `rd_ptr`, decrement remaining. When remaining reaches 1→0, pop the length queue and assert `rd_last` with that word.
  - `rd_en` with `rd_frame_ready` low: ignored.
  - `rd_discard` with `rd_frame_ready` high: `rd_ptr`+=remaining, pop the length queue; no data output.
  - `rd_discard` has priority over `rd_en` in the same cycle.
- **Reset**
  - All pointers, counters and the length queue clear; write state = IDLE.
  - Outputs: `rd_frame_ready`=0, `rd_frame_len`=0, `rd_data_valid`=0, `rd_data`=0, `rd_bytes_valid`=0, `rd_last`=0, both counters 0.
  - Reset mid-frame or mid-read discards everything.

## Timing
- `rd_en` → `rd_data_valid`/`rd_data`/`rd_last`: 1 cycle (registered RAM read). Back-to-back `rd_en` gives one word per cycle.
- `rx_commit` edge → `rd_frame_ready` high: next cycle, with `rd_frame_len` valid in that same cycle.
- After the last word is popped, the next frame's `rd_frame_ready`/`rd_frame_len` is valid the following cycle.
- `rd_frame_ready` drops in the cycle after the last pop or discard if no frames remain.
- Space freed by a read is visible to the write side on the next cycle.
- A simultaneous read and write in the same cycle is legal; the RAM is simple dual-port with no bypass, and the write frame is never readable until committed.
- Lengths and ceil(len/4) use 11-bit unsigned arithmetic; pointer differences are modulo 2·DEPTH.

## Test plan
- **Single frame.** Send 60 bytes: start, 15 words, commit. Expect `rd_frame_len`=60 one cycle after commit. 15×`rd_en` returns the data in order, `rd_last` on word 15, `rd_bytes_valid`=4. `frames_committed`=1.
- **Odd length.** Send a 61-byte frame with a final `rx_bytes_valid`=1. Expect 16 words, the last with `rd_bytes_valid`=1 and `rd_last`=1.
- **Overflow.** With DEPTH=16, send a 20-word frame with no reads. Expect `rd_frame_ready`=0 after commit, `frames_dropped`=1, and a following 8-byte frame delivered intact.
- **Drop and link loss.** Drop a frame via `rx_drop`; abort a second by taking `link_up` low mid-frame; then send a good 64-byte frame. Expect only the 64-byte frame to be readable and both counters unchanged except `frames_committed`=1.
- **Discard and queue full.** Commit 3 frames (100, 200, 64 bytes). Issue `rd_discard` on the first, read 2 words of the second, then discard it. Expect the head to show 64. Also fill MAX_FRAMES=16 frames; the 17th commit increments `frames_dropped`.
- **Asynchronous reset.** Assert `rst` mid-read and mid-write. Expect all outputs 0 immediately, and a clean frame afterwards delivered correctly.
